// File: rtl/fire_alarm_ctrl.sv
// Home fire-alarm sequencer: smoke confirmation, latched siren, timed silence, self-test, event count.
// Optional sprinkler output is built when the FIRE_SPRINKLER_EN macro is defined.
module fire_alarm_ctrl #(
    parameter logic [7:0]  SMOKE_TH      = 8'd4,
    parameter logic [7:0]  CLEAR_TH      = 8'd2,
    parameter int unsigned CONFIRM_CYC   = 4,
    parameter int unsigned SILENCE_CYC   = 16,
    parameter int unsigned TEST_CYC      = 8,
    parameter int unsigned SPRINKLER_CYC = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] smoke_detector,
    input  logic       ack,
    input  logic       test_req,
`ifdef FIRE_SPRINKLER_EN
    output logic       sprinkler_on,
`endif
    output logic       alarmEnable,
    output logic [2:0] alarm_state,
    output logic [7:0] alarm_events
);

    localparam int unsigned TmrMax = (SILENCE_CYC > TEST_CYC) ? SILENCE_CYC : TEST_CYC;
    localparam int unsigned CntW   = $clog2(CONFIRM_CYC + 1);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    if (CLEAR_TH >= SMOKE_TH || CONFIRM_CYC == 0 || SPRINKLER_CYC == 0) begin : g_bad_param
        $error("fire_alarm_ctrl: invalid parameter set");
    end

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StConfirm  = 3'd1,
        StAlarm    = 3'd2,
        StSilenced = 3'd3,
        StTest     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [7:0]        events_q, events_d;
    logic              ack_q, test_q;
    logic              high, ack_p, test_p;
    logic              alarm_entry;

    assign high   = (smoke_detector >= SMOKE_TH);
    assign ack_p  = ack & ~ack_q;
    assign test_p = test_req & ~test_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        events_d    = events_q;
        alarm_entry = 1'b0;
        unique case (state_q)
            StIdle, StTest: begin
                if (high) begin
                    // A single required sample skips CONFIRM entirely.
                    if (CONFIRM_CYC == 1) begin
                        state_d     = StAlarm;
                        alarm_entry = 1'b1;
                    end else begin
                        state_d = StConfirm;
                        cnt_d   = CntW'(1);
                    end
                end else if (state_q == StIdle) begin
                    if (test_p) begin
                        state_d = StTest;
                        tmr_d   = '0;
                    end
                end else if (ack_p || tmr_q == TmrW'(TEST_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StConfirm: begin
                if (!high) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(CONFIRM_CYC - 1)) begin
                    state_d     = StAlarm;
                    alarm_entry = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAlarm: begin
                if (ack_p) begin
                    state_d = StSilenced;
                    tmr_d   = '0;
                end
            end
            StSilenced: begin
                if (tmr_q == TmrW'(SILENCE_CYC - 1)) begin
                    state_d = high ? StAlarm : StIdle;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (alarm_entry) begin
            cnt_d = '0;
            if (events_q != 8'hFF) begin
                events_d = events_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            tmr_q    <= '0;
            events_q <= '0;
            ack_q    <= 1'b0;
            test_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            events_q <= events_d;
            ack_q    <= ack;
            test_q   <= test_req;
        end
    end

    assign alarmEnable  = (state_q == StAlarm) || (state_q == StTest);
    assign alarm_state  = state_q;
    assign alarm_events = events_q;

`ifdef FIRE_SPRINKLER_EN
    localparam int unsigned SprW = $clog2(SPRINKLER_CYC + 1);

    logic [SprW-1:0] spr_tmr_q, spr_tmr_d;
    logic            spr_on_q, spr_on_d;

    // Timer accumulates total ALARM time of one incident, pausing while silenced.
    always_comb begin
        spr_tmr_d = spr_tmr_q;
        spr_on_d  = spr_on_q;
        if (alarm_entry) begin
            spr_tmr_d = '0;
        end else if (state_q == StAlarm && spr_tmr_q != SprW'(SPRINKLER_CYC)) begin
            spr_tmr_d = spr_tmr_q + SprW'(1);
        end
        if (state_q == StAlarm && spr_tmr_q == SprW'(SPRINKLER_CYC - 1)) begin
            spr_on_d = 1'b1;
        end
        if (state_d == StIdle) begin
            spr_on_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spr_tmr_q <= '0;
            spr_on_q  <= 1'b0;
        end else begin
            spr_tmr_q <= spr_tmr_d;
            spr_on_q  <= spr_on_d;
        end
    end

    assign sprinkler_on = spr_on_q;
`endif

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Scoreboard bench for fire_alarm_ctrl: driver queues per-cycle expectations, monitor checks them.
module tb_fire_alarm_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] smoke_detector;
    logic       ack;
    logic       test_req;
    logic       alarmEnable;
    logic [2:0] alarm_state;
    logic [7:0] alarm_events;
`ifdef FIRE_SPRINKLER_EN
    logic       sprinkler_on;
    localparam int Base = 1;
`else
    localparam int Base = 0;
`endif

    fire_alarm_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .smoke_detector (smoke_detector),
        .ack            (ack),
        .test_req       (test_req),
`ifdef FIRE_SPRINKLER_EN
        .sprinkler_on   (sprinkler_on),
`endif
        .alarmEnable    (alarmEnable),
        .alarm_state    (alarm_state),
        .alarm_events   (alarm_events)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       en;
        logic [7:0] ev;
        logic       spr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic exp_spr = 1'b0;
    logic spr_chk = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Inputs change just after the falling edge; the expectation is for the next rising edge.
    task automatic step(input int r, input int s, input int a, input int t,
                        input int st, input int ev);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n          = r[0];
        smoke_detector = s[7:0];
        ack            = a[0];
        test_req       = t[0];
        e.st  = st[2:0];
        e.en  = (st == 2) || (st == 4);
        e.ev  = ev[7:0];
        e.spr = exp_spr;
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input int r, input int s, input int a, input int t,
                        input int st, input int ev);
        for (int i = 0; i < n; i++) step(r, s, a, t, st, ev);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("alarm_state", int'(alarm_state), int'(mon_e.st));
            chk("alarmEnable", int'(alarmEnable), int'(mon_e.en));
            chk("alarm_events", int'(alarm_events), int'(mon_e.ev));
`ifdef FIRE_SPRINKLER_EN
            if (spr_chk) chk("sprinkler_on", int'(sprinkler_on), int'(mon_e.spr));
`endif
        end
    end

    initial begin
        int up_st [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2};
        int cur;
        int nxt;
        rst_n = 1'b0;
        smoke_detector = 8'd0;
        ack = 1'b0;
        test_req = 1'b0;

        hold(2, 0, 0, 0, 0, 0, 0);

        // Ramp up then down, two cycles per level
        for (int i = 0; i < 16; i++) step(1, i / 2, 0, 0, up_st[i], (i >= 11) ? 1 : 0);
        for (int i = 0; i < 16; i++) step(1, 7 - i / 2, 0, 0, 2, 1);

        // Held ack silences once, re-arm with smoke present
        step(1, 7, 1, 0, 3, 1);
        hold(15, 1, 7, 1, 0, 3, 1);
        hold(3, 1, 7, 1, 0, 2, 1);
        step(1, 7, 0, 0, 2, 1);

        // Silence ends in IDLE with low and with in-band smoke
        step(1, 1, 1, 0, 3, 1);
        hold(15, 1, 1, 0, 0, 3, 1);
        step(1, 1, 0, 0, 0, 1);
        hold(3, 1, 7, 0, 0, 1, 1);
        step(1, 7, 0, 0, 2, 2);
        step(1, 3, 1, 0, 3, 2);
        hold(15, 1, 3, 0, 0, 3, 2);
        step(1, 3, 0, 0, 0, 2);

        // Glitches and hysteresis band
        hold(3, 1, 5, 0, 0, 1, 2);
        step(1, 0, 0, 0, 0, 2);
        hold(20, 1, 3, 0, 0, 0, 2);
        hold(2, 1, 5, 0, 0, 1, 2);
        step(1, 3, 0, 0, 0, 2);

        // Self-test with held request, priority of smoke, smoke during test
        hold(8, 1, 0, 0, 1, 4, 2);
        hold(2, 1, 0, 0, 1, 0, 2);
        step(1, 0, 0, 0, 0, 2);
        step(1, 6, 0, 1, 1, 2);
        step(1, 0, 0, 0, 0, 2);
        step(1, 0, 0, 1, 4, 2);
        hold(3, 1, 6, 0, 0, 1, 2);
        step(1, 6, 0, 0, 2, 3);
        step(1, 6, 0, 1, 2, 3);
        step(1, 0, 0, 0, 2, 3);

        // Reset mid-ALARM
        spr_chk = 1'b1;
        step(0, 7, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

`ifdef FIRE_SPRINKLER_EN
        hold(3, 1, 7, 0, 0, 1, 0);
        step(1, 7, 0, 0, 2, 1);
        hold(31, 1, 7, 0, 0, 2, 1);
        exp_spr = 1'b1;
        step(1, 7, 0, 0, 2, 1);
        step(1, 0, 1, 0, 3, 1);
        hold(15, 1, 0, 0, 0, 3, 1);
        exp_spr = 1'b0;
        step(1, 0, 0, 0, 0, 1);
`endif

        // Ack aborts self-test
        step(1, 0, 0, 1, 4, Base);
        step(1, 0, 1, 0, 0, Base);
        step(1, 0, 0, 0, 0, Base);

        // Event counter saturation
        cur = Base;
        for (int k = 0; k < 260; k++) begin
            nxt = (cur < 255) ? cur + 1 : 255;
            hold(3, 1, 7, 0, 0, 1, cur);
            step(1, 7, 0, 0, 2, nxt);
            step(1, 0, 1, 0, 3, nxt);
            hold(15, 1, 0, 0, 0, 3, nxt);
            step(1, 0, 0, 0, 0, nxt);
            cur = nxt;
        end

        repeat (3) @(negedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
